// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with a fill count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a registered or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int POINTER_WIDTH = $clog2(FIFO_DEPTH),
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [FIFO_WIDTH-1:0]    D_IN,
  input  logic                     Wr_Req,
  input  logic                     Rd_Req,
  output logic [FIFO_WIDTH-1:0]    D_OUT,
  output logic                     TX_D_Valid,
  output logic                     Wr_Ack,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Almost_Full,
  output logic                     Almost_Empty,
  output logic [POINTER_WIDTH:0]   Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int CW = POINTER_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic                     full, empty;
  logic                     wr_en, rd_en;
  logic [POINTER_WIDTH-1:0] wr_addr, rd_addr;

  // Flags decode straight from the registered count, so they carry no extra latency.
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign wr_en   = Wr_Req && !full;
  assign rd_en   = Rd_Req && !empty;
  assign wr_addr = wr_ptr_q[POINTER_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[POINTER_WIDTH-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_en;
    overflow_d  = Wr_Req && full;
    underflow_d = Rd_Req && empty;
    if (wr_en) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + CW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only meaningful behind
  // the pointers, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= D_IN;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of the queue is always visible; a pop exposes the next entry as rd_ptr moves.
      assign D_OUT      = mem[rd_addr];
      assign TX_D_Valid = !empty;
    end else begin : g_registered
      logic [FIFO_WIDTH-1:0] d_out_q, d_out_d;
      logic                  tx_valid_q, tx_valid_d;

      always_comb begin
        d_out_d    = d_out_q;
        tx_valid_d = rd_en;
        if (rd_en) d_out_d = mem[rd_addr];
      end

      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          d_out_q    <= '0;
          tx_valid_q <= 1'b0;
        end else begin
          d_out_q    <= d_out_d;
          tx_valid_q <= tx_valid_d;
        end
      end

      assign D_OUT      = d_out_q;
      assign TX_D_Valid = tx_valid_q;
    end
  endgenerate

  assign Wr_Ack       = wr_ack_q;
  assign Full         = full;
  assign Empty        = empty;
  assign Almost_Full  = (count_q >= AFULL_C);
  assign Almost_Empty = (count_q <= AEMPTY_C);
  assign Count        = count_q;
  assign Overflow     = overflow_q;
  assign Underflow    = underflow_q;

endmodule
